// File: rtl/dbg_ctrl_pkg.sv
// Shared state encoding and dcsr cause codes for the debug halt controller.
// Cause CAUSE_RESETHALT is only produced when DBG_HALT_ON_RESET_EN is defined.
package dbg_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN,
        DRAIN,
        HALT_SAVE,
        HALTED,
        RESUME,
        STEP
    } dbg_state_e;

    localparam logic [1:0] CAUSE_EBREAK    = 2'b00;
    localparam logic [1:0] CAUSE_HALTREQ   = 2'b01;
    localparam logic [1:0] CAUSE_STEP      = 2'b10;
    localparam logic [1:0] CAUSE_RESETHALT = 2'b11;

endpackage

// File: rtl/dbg_drain_timer.sv
// Drain counter: counts cycles while enabled, clears on request, and flags
// the last allowed drain cycle (count == DRAIN_TIMEOUT-1).
module dbg_drain_timer #(
    parameter int DRAIN_TIMEOUT = 16,
    parameter int CNT_W         = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic timeout_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DRAIN_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/debug_halt_controller.sv
// Debug halt/resume/single-step sequencer between the DM, the pipeline and the Debug CSRs.
// Optional halt-on-reset behaviour is enabled with the macro DBG_HALT_ON_RESET_EN.
module debug_halt_controller
    import dbg_ctrl_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = 16,
    parameter int CNT_W         = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        dm_haltreq_i,
    input  logic        dm_resumereq_i,
    input  logic        ebreak_i,
    input  logic        instr_retire_i,
    input  logic        pipeline_empty_i,
    input  logic        DSP_dcsr_step_i,
    input  logic        DSP_dcsr_ebreakm_i,
    input  logic [31:0] resume_pc_i,
    output logic        DSP_reg_access_o,
    output logic [1:0]  DSP_cause_control_o,
    output logic        DSP_status_reset_o,
    output logic        pipeline_stall_o,
    output logic        pipeline_flush_o,
    output logic        pc_redirect_o,
    output logic [31:0] pc_redirect_addr_o,
    output logic        dm_halted_o,
    output logic        dm_running_o,
    output logic        dm_resumeack_o
);

`ifdef DBG_HALT_ON_RESET_EN
    localparam dbg_state_e RESET_STATE = HALT_SAVE;
    localparam logic [1:0] RESET_CAUSE = CAUSE_RESETHALT;
`else
    localparam dbg_state_e RESET_STATE = RUN;
    localparam logic [1:0] RESET_CAUSE = CAUSE_EBREAK;
`endif

    dbg_state_e  state_q, state_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] addr_q, addr_d;
    logic        drain_timeout;
    logic        ebreak_hit;

    assign ebreak_hit = ebreak_i & DSP_dcsr_ebreakm_i;

    dbg_drain_timer #(
        .DRAIN_TIMEOUT(DRAIN_TIMEOUT),
        .CNT_W        (CNT_W)
    ) u_drain_timer (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  (state_q != DRAIN),
        .enable_i (state_q == DRAIN),
        .timeout_o(drain_timeout)
    );

    always_comb begin
        state_d             = state_q;
        cause_d             = cause_q;
        addr_d              = addr_q;
        DSP_reg_access_o    = 1'b0;
        DSP_cause_control_o = 2'b00;
        DSP_status_reset_o  = 1'b0;
        pipeline_stall_o    = 1'b0;
        pipeline_flush_o    = 1'b0;
        pc_redirect_o       = 1'b0;
        dm_halted_o         = 1'b0;
        dm_running_o        = 1'b0;
        dm_resumeack_o      = 1'b0;
        case (state_q)
            RUN: begin
                dm_running_o = 1'b1;
                if (ebreak_hit) begin
                    state_d = HALT_SAVE;
                    cause_d = CAUSE_EBREAK;
                end else if (dm_haltreq_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Halt is committed once draining starts; haltreq dropping does not abort it.
                pipeline_stall_o = 1'b1;
                if (ebreak_hit) begin
                    state_d = HALT_SAVE;
                    cause_d = CAUSE_EBREAK;
                end else if (pipeline_empty_i || drain_timeout) begin
                    state_d = HALT_SAVE;
                    cause_d = CAUSE_HALTREQ;
                end
            end
            HALT_SAVE: begin
                DSP_reg_access_o    = 1'b1;
                DSP_cause_control_o = cause_q;
                pipeline_flush_o    = 1'b1;
                pipeline_stall_o    = 1'b1;
                state_d             = HALTED;
            end
            HALTED: begin
                pipeline_stall_o = 1'b1;
                dm_halted_o      = 1'b1;
                if (dm_resumereq_i && !dm_haltreq_i) begin
                    state_d = RESUME;
                    addr_d  = resume_pc_i;
                end
            end
            RESUME: begin
                DSP_status_reset_o = 1'b1;
                pc_redirect_o      = 1'b1;
                dm_resumeack_o     = 1'b1;
                state_d            = DSP_dcsr_step_i ? STEP : RUN;
            end
            STEP: begin
                dm_running_o = 1'b1;
                if (ebreak_hit) begin
                    state_d = HALT_SAVE;
                    cause_d = CAUSE_EBREAK;
                end else if (instr_retire_i) begin
                    state_d = HALT_SAVE;
                    cause_d = CAUSE_STEP;
                end
            end
            default: state_d = RUN;
        endcase
`ifdef DBG_HALT_ON_RESET_EN
        // Hold the hart frozen while reset is applied; the save strobe follows release.
        if (reset_i) begin
            DSP_reg_access_o    = 1'b0;
            DSP_cause_control_o = 2'b00;
            DSP_status_reset_o  = 1'b0;
            pipeline_stall_o    = 1'b1;
            pipeline_flush_o    = 1'b0;
            pc_redirect_o       = 1'b0;
            dm_halted_o         = 1'b0;
            dm_running_o        = 1'b0;
            dm_resumeack_o      = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= RESET_STATE;
            cause_q <= RESET_CAUSE;
            addr_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            addr_q  <= addr_d;
        end
    end

    assign pc_redirect_addr_o = addr_q;

endmodule

// File: tb/tb_debug_halt_controller.sv
// Self-checking bench for debug_halt_controller: directed test-plan scenarios
// followed by randomized traffic compared every cycle against a behavioural model.
module tb_debug_halt_controller;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        haltreq = 0, resumereq = 0, ebreak = 0, retire = 0, empty = 0;
    logic        step = 0, ebreakm = 0;
    logic [31:0] resume_pc = 0;

    logic        reg_access, status_reset, stall, flush, redirect;
    logic        halted, running, resumeack;
    logic [1:0]  cause;
    logic [31:0] redirect_addr;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    debug_halt_controller #(.DRAIN_TIMEOUT(T), .CNT_W(8)) dut (
        .clk_i              (clk),
        .reset_i            (rst),
        .dm_haltreq_i       (haltreq),
        .dm_resumereq_i     (resumereq),
        .ebreak_i           (ebreak),
        .instr_retire_i     (retire),
        .pipeline_empty_i   (empty),
        .DSP_dcsr_step_i    (step),
        .DSP_dcsr_ebreakm_i (ebreakm),
        .resume_pc_i        (resume_pc),
        .DSP_reg_access_o   (reg_access),
        .DSP_cause_control_o(cause),
        .DSP_status_reset_o (status_reset),
        .pipeline_stall_o   (stall),
        .pipeline_flush_o   (flush),
        .pc_redirect_o      (redirect),
        .pc_redirect_addr_o (redirect_addr),
        .dm_halted_o        (halted),
        .dm_running_o       (running),
        .dm_resumeack_o     (resumeack)
    );

    task automatic ck1(input string nm, input logic got, input logic exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, got, exp);
        end
    endtask

    task automatic ck32(input string nm, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    // Behavioural model: which phase of the halt/resume story the hart is in.
    bit          m_drain = 0, m_save = 0, m_halt = 0, m_res = 0, m_step = 0;
    int          m_dn = 0;
    logic [1:0]  m_cause = 2'b00;
    logic [31:0] m_pc = 32'h0;
    wire         eb = ebreak & ebreakm;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_drain <= 0; m_save <= 0; m_halt <= 0; m_res <= 0; m_step <= 0;
            m_dn <= 0; m_pc <= 32'h0;
        end else if (m_save) begin
            m_save <= 0; m_halt <= 1;
        end else if (m_halt) begin
            if (resumereq && !haltreq) begin
                m_halt <= 0; m_res <= 1; m_pc <= resume_pc;
            end
        end else if (m_res) begin
            m_res <= 0; m_step <= step;
        end else if (m_drain) begin
            if (eb) begin
                m_drain <= 0; m_save <= 1; m_cause <= 2'b00;
            end else if (empty || m_dn == T - 1) begin
                m_drain <= 0; m_save <= 1; m_cause <= 2'b01;
            end else begin
                m_dn <= m_dn + 1;
            end
        end else if (eb || (m_step && retire)) begin
            m_step <= 0; m_save <= 1; m_cause <= eb ? 2'b00 : 2'b10;
        end else if (!m_step && haltreq) begin
            m_drain <= 1; m_dn <= 0;
        end
    end

    always @(negedge clk) begin
        ck1("stall", stall, m_drain | m_save | m_halt);
        ck1("flush", flush, m_save);
        ck1("reg_access", reg_access, m_save);
        ck1("status_reset", status_reset, m_res);
        ck1("redirect", redirect, m_res);
        ck1("resumeack", resumeack, m_res);
        ck1("halted", halted, m_halt);
        ck1("running", running, !(m_drain | m_save | m_halt | m_res));
        if (reg_access) ck32("cause", 32'(cause), 32'(m_cause));
        if (redirect) ck32("redirect_addr", redirect_addr, m_pc);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_resume(input logic with_step);
        resumereq = 1; step = with_step;
        tick();
        resumereq = 0;
        tick();
    endtask

    initial begin
        int n;
        #1 rst = 1;
        tick(); tick();
        ck1("rst_running", running, 1'b1);
        ck1("rst_stall", stall, 1'b0);
        ck1("rst_halted", halted, 1'b0);
        ck1("rst_reg_access", reg_access, 1'b0);
        ck32("rst_addr", redirect_addr, 32'h0);
        rst = 0;
        tick();

        // ebreak with ebreakm: strobe one cycle later, then halted
        ebreakm = 1; ebreak = 1;
        tick();
        ebreak = 0;
        ck1("eb_strobe", reg_access, 1'b1);
        ck32("eb_cause", 32'(cause), 32'h0);
        ck1("eb_flush", flush, 1'b1);
        tick();
        ck1("eb_halted", halted, 1'b1);
        ck1("eb_not_running", running, 1'b0);

        // resume to 0x104
        resume_pc = 32'h0000_0104; resumereq = 1; step = 0;
        tick();
        resumereq = 0;
        ck1("res_redirect", redirect, 1'b1);
        ck32("res_addr", redirect_addr, 32'h104);
        ck1("res_ack", resumeack, 1'b1);
        ck1("res_status_reset", status_reset, 1'b1);
        ck1("res_stall", stall, 1'b0);
        tick();
        ck1("res_running", running, 1'b1);
        ck1("res_ack_gone", resumeack, 1'b0);

        // haltreq, pipeline empty 3 cycles later
        haltreq = 1;
        tick();
        ck1("hr_stall_c1", stall, 1'b1);
        ck1("hr_running_c1", running, 1'b0);
        tick();
        tick();
        ck1("hr_no_strobe_c3", reg_access, 1'b0);
        empty = 1;
        tick();
        haltreq = 0; empty = 0;
        ck1("hr_strobe_c4", reg_access, 1'b1);
        ck32("hr_cause_c4", 32'(cause), 32'h1);
        tick();
        ck1("hr_halted_c5", halted, 1'b1);

        // single step: retire 5 cycles into STEP
        do_resume(1'b1);
        ck1("st_running", running, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            ck1("st_no_strobe", reg_access, 1'b0);
        end
        retire = 1;
        tick();
        retire = 0;
        ck1("st_strobe", reg_access, 1'b1);
        ck32("st_cause", 32'(cause), 32'h2);
        tick();
        ck1("st_halted", halted, 1'b1);

        // resumereq ignored while haltreq high
        haltreq = 1; resumereq = 1; step = 0;
        tick();
        resumereq = 0;
        ck1("hold_halted", halted, 1'b1);
        ck1("hold_no_ack", resumeack, 1'b0);
        haltreq = 0;
        tick();
        ck1("hold_still_halted", halted, 1'b1);
        do_resume(1'b0);
        ck1("hold_resumed", running, 1'b1);

        // drain timeout with pipeline never empty
        haltreq = 1; empty = 0;
        tick();
        n = 0;
        while (stall && !reg_access && n < 40) begin
            n++;
            tick();
        end
        haltreq = 0;
        ck32("to_drain_cycles", 32'(n), 32'(T));
        ck1("to_strobe", reg_access, 1'b1);
        ck32("to_cause", 32'(cause), 32'h1);
        ck1("to_flush", flush, 1'b1);
        tick();
        ck1("to_halted", halted, 1'b1);
        do_resume(1'b0);

        // reset asserted mid-drain
        haltreq = 1;
        tick();
        tick();
        ck1("rd_in_drain", stall, 1'b1);
        rst = 1;
        #1;
        ck1("rd_running", running, 1'b1);
        ck1("rd_stall", stall, 1'b0);
        ck1("rd_no_strobe", reg_access, 1'b0);
        haltreq = 0;
        tick();
        ck1("rd_no_strobe2", reg_access, 1'b0);
        rst = 0;
        tick();
        ck1("rd_after_running", running, 1'b1);
        ck1("rd_after_no_strobe", reg_access, 1'b0);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            haltreq   = ($urandom_range(0, 7) == 0);
            resumereq = ($urandom_range(0, 3) == 0);
            ebreak    = ($urandom_range(0, 15) == 0);
            ebreakm   = $urandom_range(0, 1) == 1;
            retire    = ($urandom_range(0, 2) == 0);
            empty     = ($urandom_range(0, 5) == 0);
            step      = $urandom_range(0, 1) == 1;
            resume_pc = $urandom;
            if ($urandom_range(0, 299) == 0) rst = 1;
            tick();
            rst = 0;
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
